// File: rtl/wfg_wb_master.sv
// wfg_wb_master: single-outstanding Wishbone classic initiator.
// Turns a valid/ready command stream into one Wishbone cycle at a time and
// returns read data (or a timeout error) on a valid/ready response stream.
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock, async active-low reset
//   cmd_valid_i/cmd_ready_o      command handshake
//   cmd_we_i/adr_i/dat_i/sel_i   command payload (write enable, address, data, byte selects)
//   rsp_valid_o/rsp_ready_i      response handshake
//   rsp_dat_o, rsp_err_o         read data (0 for writes/errors), timeout flag
//   wbm_*                        Wishbone classic master side
//   busy_o                       high whenever a transaction is in flight or pending response
module wfg_wb_master #(
   parameter int BUSW           = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TOW            = 8
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_ni,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_we_i,
   input  logic [BUSW-1:0]     cmd_adr_i,
   input  logic [BUSW-1:0]     cmd_dat_i,
   input  logic [BUSW/8-1:0]   cmd_sel_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [BUSW-1:0]     rsp_dat_o,
   output logic                rsp_err_o,
   output logic                wbm_cyc_o,
   output logic                wbm_stb_o,
   output logic                wbm_we_o,
   output logic [BUSW/8-1:0]   wbm_sel_o,
   output logic [BUSW-1:0]     wbm_adr_o,
   output logic [BUSW-1:0]     wbm_dat_o,
   input  logic [BUSW-1:0]     wbm_dat_i,
   input  logic                wbm_ack_i,
   output logic                busy_o
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   localparam bit             TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [TOW-1:0] TMO_LAST = TMO_EN ? TOW'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [TOW-1:0] CNT_ONE  = TOW'(1);

   state_t         state, state_nx;
   logic [TOW-1:0] tcnt;
   logic           accept, ack_hit, tmo_hit, rsp_done;

   assign cmd_ready_o = (state == IDLE);
   assign busy_o      = (state != IDLE);

   // Next state and one-cycle event strobes for the datapath register.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      ack_hit  = 1'b0;
      tmo_hit  = 1'b0;
      rsp_done = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid_i) begin
               accept   = 1'b1;
               state_nx = BUS;
            end
         end
         BUS: begin
            // Ack has priority over a timeout landing on the same edge.
            if (wbm_ack_i) begin
               ack_hit  = 1'b1;
               state_nx = RESP;
            end else if (TMO_EN && (tcnt == TMO_LAST)) begin
               tmo_hit  = 1'b1;
               state_nx = RESP;
            end
         end
         RESP: begin
            // rsp_valid_o is always high in RESP, so ready alone completes it.
            if (rsp_ready_i) begin
               rsp_done = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) state <= IDLE;
      else            state <= state_nx;
   end

   // Registered bus and response outputs. Address/data/sel/we are left at
   // their last values after a transaction; only cyc/stb qualify them.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         wbm_cyc_o   <= 1'b0;
         wbm_stb_o   <= 1'b0;
         wbm_we_o    <= 1'b0;
         wbm_sel_o   <= '0;
         wbm_adr_o   <= '0;
         wbm_dat_o   <= '0;
         rsp_valid_o <= 1'b0;
         rsp_dat_o   <= '0;
         rsp_err_o   <= 1'b0;
         tcnt        <= '0;
      end else begin
         if (accept) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= cmd_we_i;
            wbm_sel_o <= cmd_sel_i;
            wbm_adr_o <= cmd_adr_i;
            wbm_dat_o <= cmd_dat_i;
            tcnt      <= '0;
         end
         if (state == BUS && !wbm_ack_i) tcnt <= tcnt + CNT_ONE;
         if (ack_hit || tmo_hit) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= tmo_hit;
            rsp_dat_o   <= (ack_hit && !wbm_we_o) ? wbm_dat_i : '0;
         end
         if (rsp_done) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_dat_o   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_wfg_wb_master.sv
// Bench for wfg_wb_master with a registered-ack slave model (4 KiB window,
// ack only below 0x400 and at 0xFFC) plus an injectable stray ack.
module tb_wfg_wb_master;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr, cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_dat;
   logic        wbm_cyc, wbm_stb, wbm_we, wbm_ack;
   logic [3:0]  wbm_sel;
   logic [31:0] wbm_adr, wbm_dat_o, wbm_dat_i;
   logic        busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wfg_wb_master #(.BUSW(32), .TIMEOUT_CYCLES(16), .TOW(8)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
      .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
      .rsp_err_o(rsp_err), .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb),
      .wbm_we_o(wbm_we), .wbm_sel_o(wbm_sel), .wbm_adr_o(wbm_adr),
      .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack),
      .busy_o(busy)
   );

   // ---------------- slave model ----------------
   logic [31:0] mem [0:1023];
   logic        mem_clear;
   logic        sl_ack, xack;
   logic [31:0] sl_dat;
   logic [9:0]  idx;
   logic        addr_ok, sl_hit;

   assign idx       = wbm_adr[11:2];
   assign addr_ok   = (wbm_adr < 32'h400) || (wbm_adr == 32'hFFC);
   assign sl_hit    = wbm_cyc && wbm_stb && !sl_ack && addr_ok;
   assign wbm_ack   = sl_ack | xack;
   assign wbm_dat_i = xack ? 32'hDEADBEEF : sl_dat;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sl_ack <= 1'b0;
         sl_dat <= 32'h0;
      end else begin
         sl_ack <= sl_hit;
         if (sl_hit) sl_dat <= mem[idx];
      end
   end

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
         mem[7]    <= 32'h0000_4000;   // 0x1C
         mem[1023] <= 32'h0000_0101;   // 0xFFC
      end else if (sl_hit && wbm_we) begin
         for (int b = 0; b < 4; b++)
            if (wbm_sel[b]) mem[idx][8*b +: 8] <= wbm_dat_o[8*b +: 8];
      end
   end

   // cyc must never be high while a response is pending
   int overlap = 0;
   int cyc_rises = 0;
   logic cyc_prev = 1'b0;
   always @(negedge clk) begin
      if (rsp_valid && wbm_cyc) overlap <= overlap + 1;
      if (wbm_cyc && !cyc_prev) cyc_rises <= cyc_rises + 1;
      cyc_prev <= wbm_cyc;
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_txn(input string nm, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input logic [31:0] exp_dat, input logic exp_err, input int exp_cyc);
      int  n, cyc;
      bit  got;
      @(negedge clk);
      cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1 cmd_valid = 1'b0;
      cyc = 0; got = 0; n = 0;
      while (!got && n < 100) begin
         @(negedge clk); n++;
         if (rsp_valid) got = 1;
         else if (wbm_cyc && wbm_stb) begin
            if (cyc == 0) begin
               check({nm, "_adr"}, wbm_adr, adr);
               check({nm, "_we"},  {31'h0, wbm_we}, {31'h0, we});
               check({nm, "_sel"}, {28'h0, wbm_sel}, {28'h0, sel});
               if (we) check({nm, "_wdat"}, wbm_dat_o, dat);
            end
            cyc++;
         end
      end
      check({nm, "_rsp_seen"}, {31'h0, got}, 32'h1);
      check({nm, "_cyc_len"}, cyc, exp_cyc);
      check({nm, "_rdat"}, rsp_dat, exp_dat);
      check({nm, "_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
      check({nm, "_cyc_low_in_resp"}, {31'h0, wbm_cyc}, 32'h0);
      @(negedge clk);
      check({nm, "_rsp_cleared"}, {31'h0, rsp_valid}, 32'h0);
      check({nm, "_idle_after"}, {30'h0, busy, cmd_ready}, 32'h1);
   endtask

   typedef struct {
      string       nm;
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] exp_dat;
      logic        exp_err;
      int          exp_cyc;
   } vec_t;

   vec_t vecs [7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"wr10",   1'b1, 32'h10,  32'h1,         4'hF, 32'h0,         1'b0, 2};
      vecs[1] = '{"rd10",   1'b0, 32'h10,  32'h0,         4'hF, 32'h1,         1'b0, 2};
      vecs[2] = '{"rd1c",   1'b0, 32'h1C,  32'h0,         4'hF, 32'h0000_4000, 1'b0, 2};
      vecs[3] = '{"rdffc",  1'b0, 32'hFFC, 32'h0,         4'hF, 32'h0000_0101, 1'b0, 2};
      vecs[4] = '{"wr20s3", 1'b1, 32'h20,  32'hA5A5_5A5A, 4'h3, 32'h0,         1'b0, 2};
      vecs[5] = '{"rd20",   1'b0, 32'h20,  32'h0,         4'hF, 32'h0000_5A5A, 1'b0, 2};
      vecs[6] = '{"tmo500", 1'b0, 32'h500, 32'h0,         4'hF, 32'h0,         1'b1, 16};

      rst_n = 1'b0; mem_clear = 1'b1; xack = 1'b0; rsp_ready = 1'b1;
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
      repeat (2) @(negedge clk);
      check("rst_cyc_stb", {30'h0, wbm_cyc, wbm_stb}, 32'h0);
      check("rst_bus_regs", wbm_adr | wbm_dat_o | {27'h0, wbm_we, wbm_sel}, 32'h0);
      check("rst_rsp", rsp_dat | {30'h0, rsp_valid, rsp_err}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      rst_n = 1'b1; mem_clear = 1'b0;
      @(negedge clk);
      check("post_rst_ready", {31'h0, cmd_ready}, 32'h1);

      // Table-driven single transactions (write/readback, sine regs, sel, timeout)
      for (int i = 0; i < 7; i++)
         do_txn(vecs[i].nm, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
                vecs[i].exp_dat, vecs[i].exp_err, vecs[i].exp_cyc);
      check("adr_retained", wbm_adr, 32'h500);

      // Response backpressure with a stray ack while the response is held
      begin
         int n;
         rsp_ready = 1'b0;
         @(negedge clk);
         cmd_we = 1'b0; cmd_adr = 32'h10; cmd_sel = 4'hF; cmd_valid = 1'b1;
         @(posedge clk); #1 cmd_valid = 1'b0;
         n = 0;
         while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
         check("bp_rsp_seen", {31'h0, rsp_valid}, 32'h1);
         for (int k = 0; k < 5; k++) begin
            check("bp_valid", {31'h0, rsp_valid}, 32'h1);
            check("bp_dat", rsp_dat, 32'h1);
            check("bp_err", {31'h0, rsp_err}, 32'h0);
            check("bp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
            xack = (k == 0);
            @(negedge clk);
         end
         xack = 1'b0;
         check("bp_no_cyc", {31'h0, wbm_cyc}, 32'h0);
         rsp_ready = 1'b1;
         @(negedge clk);
         check("bp_done", {30'h0, rsp_valid, busy}, 32'h0);
         check("bp_dat_clr", rsp_dat, 32'h0);
      end

      // Back-to-back writes with cmd_valid held high
      begin
         int i, n, rises0;
         logic [31:0] b2b_val [4];
         for (int j = 0; j < 4; j++) b2b_val[j] = 32'h1111_0000 * (j + 1) + 32'h0000_00C3;
         rises0 = cyc_rises;
         @(negedge clk);
         i = 0; n = 0;
         cmd_we = 1'b1; cmd_sel = 4'hF; cmd_adr = 32'h14; cmd_dat = b2b_val[0]; cmd_valid = 1'b1;
         while (i < 4 && n < 200) begin
            if (cmd_ready) begin
               @(posedge clk); #1;
               i++;
               if (i < 4) begin cmd_adr = 32'h14 + 32'(4 * i); cmd_dat = b2b_val[i]; end
               else cmd_valid = 1'b0;
            end
            @(negedge clk); n++;
         end
         cmd_valid = 1'b0;
         n = 0;
         while (busy && n < 50) begin @(negedge clk); n++; end
         check("b2b_accepted", i, 4);
         check("b2b_cyc_rises", cyc_rises - rises0, 4);
         check("b2b_overlap", overlap, 0);
         for (int j = 0; j < 4; j++)
            do_txn("b2b_rd", 1'b0, 32'h14 + 32'(4 * j), 32'h0, 4'hF, b2b_val[j], 1'b0, 2);
      end

      // Reset in the middle of a bus cycle
      @(negedge clk);
      cmd_we = 1'b0; cmd_adr = 32'h500; cmd_sel = 4'hF; cmd_valid = 1'b1;
      @(posedge clk); #1 cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_cyc_high", {30'h0, wbm_cyc, wbm_stb}, 32'h3);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_cyc_async", {30'h0, wbm_cyc, wbm_stb}, 32'h0);
      check("mid_rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("mid_rst_quiet", {30'h0, rsp_valid, wbm_cyc}, 32'h0);
      end
      check("mid_rst_ready", {31'h0, cmd_ready}, 32'h1);
      do_txn("after_rst_rd10", 1'b0, 32'h10, 32'h0, 4'hF, 32'h1, 1'b0, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
